// File: rtl/alu_y_fwd_mux.sv
// Registered, forwarding-aware ALU Y-operand selector with load-use bubble insertion.
// Define ALU_Y_FWD_CNT_EN to build the saturating forward/bubble event counters.
module alu_y_fwd_mux #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned RA_W    = 3,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] imm_data,
  input  logic [WIDTH-1:0] rf_data,
  input  logic [RA_W-1:0]  src_ra,
  input  logic             exmem_we,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic             exmem_load,
  input  logic             memwb_we,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [WIDTH-1:0] memwb_data,
  input  logic             stall,
  input  logic             flush,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic [1:0]       y_src,
  output logic             load_stall,
  output logic [15:0]      cnt_ex,
  output logic [15:0]      cnt_wb,
  output logic [15:0]      cnt_ld
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] SRC_RF  = 2'd0;
  localparam logic [1:0] SRC_IMM = 2'd1;
  localparam logic [1:0] SRC_EX  = 2'd2;
  localparam logic [1:0] SRC_WB  = 2'd3;

  typedef enum logic {RUN, LDWAIT} state_e;

  state_e           state_q, state_d;
  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic [1:0]       y_src_q, y_src_d;
  logic [RA_W-1:0]  lat_ra_q, lat_ra_d;
  logic [WIDTH-1:0] lat_rf_q, lat_rf_d;

  logic             r0_src;
  logic             ex_hit;
  logic             wb_hit;
  logic             hz;
  logic             accept;
  logic             wb_hit_wait;
  logic [1:0]       sel_src;
  logic [WIDTH-1:0] sel_data;

  // Register 0 is hard-wired, so it never matches a forwarding destination.
  assign r0_src      = R0_ZERO && (src_ra == RA_W'(0));
  assign ex_hit      = !r0_src && exmem_we && (exmem_rd == src_ra);
  assign wb_hit      = !r0_src && memwb_we && (memwb_rd == src_ra);
  assign hz          = in_valid && !use_imm && ex_hit && exmem_load;
  assign in_ready    = (state_q == RUN) && !stall;
  assign accept      = in_valid && in_ready;
  assign wb_hit_wait = memwb_we && (memwb_rd == lat_ra_q);
  assign load_stall  = (state_q == LDWAIT) || (accept && hz && !flush);

  always_comb begin
    sel_src  = SRC_RF;
    sel_data = rf_data;
    if (use_imm) begin
      sel_src  = SRC_IMM;
      sel_data = imm_data;
    end else if (ex_hit && !exmem_load) begin
      sel_src  = SRC_EX;
      sel_data = exmem_data;
    end else if (wb_hit) begin
      sel_src  = SRC_WB;
      sel_data = memwb_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_src_d   = y_src_q;
    lat_ra_d  = lat_ra_q;
    lat_rf_d  = lat_rf_q;
    if (flush) begin
      state_d   = RUN;
      y_valid_d = 1'b0;
      lat_ra_d  = '0;
      lat_rf_d  = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (stall) begin
            state_d = RUN;
          end else if (accept && !hz) begin
            y_valid_d = 1'b1;
            y_data_d  = sel_data;
            y_src_d   = sel_src;
          end else if (accept) begin
            y_valid_d = 1'b0;
            lat_ra_d  = src_ra;
            lat_rf_d  = rf_data;
            state_d   = LDWAIT;
          end else begin
            y_valid_d = 1'b0;
          end
        end
        LDWAIT: begin
          // The load has reached MEM/WB by now; take its data if it targets our register.
          if (!stall) begin
            y_valid_d = 1'b1;
            y_data_d  = wb_hit_wait ? memwb_data : lat_rf_q;
            y_src_d   = wb_hit_wait ? SRC_WB : SRC_RF;
            state_d   = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_src_q   <= SRC_RF;
      lat_ra_q  <= '0;
      lat_rf_q  <= '0;
    end else begin
      state_q   <= state_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_src_q   <= y_src_d;
      lat_ra_q  <= lat_ra_d;
      lat_rf_q  <= lat_rf_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_src   = y_src_q;

`ifdef ALU_Y_FWD_CNT_EN
  logic             ex_inc;
  logic             wb_inc;
  logic             ld_inc;
  logic [CNT_W-1:0] cnt_ex_q, cnt_wb_q, cnt_ld_q;

  // Count only operands that are actually registered (flush cancels them).
  assign ex_inc = !flush && accept && !hz && (sel_src == SRC_EX);
  assign wb_inc = !flush && ((accept && !hz && (sel_src == SRC_WB)) ||
                             ((state_q == LDWAIT) && !stall && wb_hit_wait));
  assign ld_inc = !flush && accept && hz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ex_q <= '0;
      cnt_wb_q <= '0;
      cnt_ld_q <= '0;
    end else begin
      if (ex_inc && (cnt_ex_q != '1)) cnt_ex_q <= cnt_ex_q + CNT_W'(1);
      if (wb_inc && (cnt_wb_q != '1)) cnt_wb_q <= cnt_wb_q + CNT_W'(1);
      if (ld_inc && (cnt_ld_q != '1)) cnt_ld_q <= cnt_ld_q + CNT_W'(1);
    end
  end

  assign cnt_ex = cnt_ex_q;
  assign cnt_wb = cnt_wb_q;
  assign cnt_ld = cnt_ld_q;
`else
  assign cnt_ex = CNT_W'(0);
  assign cnt_wb = CNT_W'(0);
  assign cnt_ld = CNT_W'(0);
`endif

endmodule

// File: tb/tb_alu_y_fwd_mux.sv
// Self-checking bench for alu_y_fwd_mux: directed literal checks plus randomized
// traffic compared every cycle against a behavioural operand-selection model.
module tb_alu_y_fwd_mux;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned RA_W  = 3;
`ifdef ALU_Y_FWD_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid, in_ready, use_imm;
  logic [WIDTH-1:0] imm_data, rf_data, exmem_data, memwb_data;
  logic [RA_W-1:0]  src_ra, exmem_rd, memwb_rd;
  logic             exmem_we, exmem_load, memwb_we, stall, flush;
  logic             y_valid, load_stall;
  logic [WIDTH-1:0] y_data;
  logic [1:0]       y_src;
  logic [15:0]      cnt_ex, cnt_wb, cnt_ld;

  alu_y_fwd_mux dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .use_imm(use_imm), .imm_data(imm_data), .rf_data(rf_data), .src_ra(src_ra),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .exmem_load(exmem_load), .memwb_we(memwb_we), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .stall(stall), .flush(flush), .y_valid(y_valid),
    .y_data(y_data), .y_src(y_src), .load_stall(load_stall),
    .cnt_ex(cnt_ex), .cnt_wb(cnt_wb), .cnt_ld(cnt_ld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural model: what EX must see after the next edge.
  bit          m_valid = 0;
  logic [15:0] m_data = '0;
  logic [1:0]  m_src = '0;
  bit          m_wait = 0;
  logic [2:0]  m_ra = '0;
  logic [15:0] m_rf = '0;
  int          m_cex = 0, m_cwb = 0, m_cld = 0;
  bit          e_rdy, e_acc, e_hz, e_ls, e_r0;
  logic [1:0]  p_src;
  logic [15:0] p_data;

  function automatic logic [31:0] sat(input int n);
    if (!CNT_ON) return 32'd0;
    return (n > 65535) ? 32'd65535 : 32'(n);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_src = '0; m_wait = 0; m_ra = '0; m_rf = '0;
      m_cex = 0; m_cwb = 0; m_cld = 0;
    end else begin
      e_r0  = (src_ra == 3'd0);
      e_rdy = !m_wait && !stall;
      e_acc = in_valid && e_rdy;
      e_hz  = in_valid && !use_imm && exmem_we && exmem_load && (exmem_rd == src_ra) && !e_r0;
      e_ls  = m_wait || (e_acc && e_hz && !flush);
      if (use_imm) begin p_src = 2'd1; p_data = imm_data; end
      else if (!e_r0 && exmem_we && !exmem_load && exmem_rd == src_ra) begin p_src = 2'd2; p_data = exmem_data; end
      else if (!e_r0 && memwb_we && memwb_rd == src_ra) begin p_src = 2'd3; p_data = memwb_data; end
      else begin p_src = 2'd0; p_data = rf_data; end

      chk("m_y_valid", 32'(y_valid), 32'(m_valid));
      if (m_valid) begin
        chk("m_y_data", 32'(y_data), 32'(m_data));
        chk("m_y_src", 32'(y_src), 32'(m_src));
      end
      chk("m_in_ready", 32'(in_ready), 32'(e_rdy));
      chk("m_load_stall", 32'(load_stall), 32'(e_ls));
      chk("m_cnt_ex", 32'(cnt_ex), sat(m_cex));
      chk("m_cnt_wb", 32'(cnt_wb), sat(m_cwb));
      chk("m_cnt_ld", 32'(cnt_ld), sat(m_cld));

      if (flush) begin
        m_valid = 0; m_wait = 0;
      end else if (m_wait) begin
        if (!stall) begin
          m_valid = 1; m_wait = 0;
          if (memwb_we && memwb_rd == m_ra) begin m_data = memwb_data; m_src = 2'd3; m_cwb++; end
          else begin m_data = m_rf; m_src = 2'd0; end
        end
      end else if (!stall) begin
        if (e_acc && !e_hz) begin
          m_valid = 1; m_data = p_data; m_src = p_src;
          if (p_src == 2'd2) m_cex++;
          if (p_src == 2'd3) m_cwb++;
        end else if (e_acc) begin
          m_valid = 0; m_wait = 1; m_ra = src_ra; m_rf = rf_data; m_cld++;
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  task automatic idle();
    in_valid = 0; use_imm = 0; imm_data = '0; rf_data = '0; src_ra = '0;
    exmem_we = 0; exmem_rd = '0; exmem_data = '0; exmem_load = 0;
    memwb_we = 0; memwb_rd = '0; memwb_data = '0; stall = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_y_data", 32'(y_data), 32'd0);
    chk("rst_y_src", 32'(y_src), 32'd0);
    chk("rst_load_stall", 32'(load_stall), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // EX/MEM beats MEM/WB; immediate beats both.
    in_valid = 1; src_ra = 3; rf_data = 16'h1111;
    exmem_we = 1; exmem_rd = 3; exmem_data = 16'hAAAA;
    memwb_we = 1; memwb_rd = 3; memwb_data = 16'h5555;
    tick();
    chk("prio_ex_data", 32'(y_data), 32'hAAAA);
    chk("prio_ex_src", 32'(y_src), 32'd2);
    chk("prio_ex_valid", 32'(y_valid), 32'd1);
    use_imm = 1; imm_data = 16'h0007;
    tick();
    chk("prio_imm_data", 32'(y_data), 32'h0007);
    chk("prio_imm_src", 32'(y_src), 32'd1);

    // Load-use bubble resolved from MEM/WB.
    idle(); in_valid = 1; src_ra = 2; rf_data = 16'h0222;
    exmem_we = 1; exmem_load = 1; exmem_rd = 2;
    #1 chk("lu_stall_now", 32'(load_stall), 32'd1);
    tick();
    idle(); memwb_we = 1; memwb_rd = 2; memwb_data = 16'hBEEF;
    #1;
    chk("lu_bubble_valid", 32'(y_valid), 32'd0);
    chk("lu_bubble_stall", 32'(load_stall), 32'd1);
    chk("lu_bubble_ready", 32'(in_ready), 32'd0);
    tick();
    chk("lu_res_data", 32'(y_data), 32'hBEEF);
    chk("lu_res_src", 32'(y_src), 32'd3);
    chk("lu_res_valid", 32'(y_valid), 32'd1);

    // Register 0 never forwards and never hazards.
    idle(); in_valid = 1; src_ra = 0; rf_data = 16'h0000;
    exmem_we = 1; exmem_rd = 0; exmem_load = 1; exmem_data = 16'hDEAD;
    #1 chk("r0_no_stall", 32'(load_stall), 32'd0);
    tick();
    chk("r0_src", 32'(y_src), 32'd0);
    chk("r0_data", 32'(y_data), 32'd0);
    chk("r0_valid", 32'(y_valid), 32'd1);

    // Stall holds the output register.
    idle(); in_valid = 1; use_imm = 1; imm_data = 16'h0042;
    tick();
    chk("st_pre_data", 32'(y_data), 32'h0042);
    imm_data = 16'h0099; stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("st_ready", 32'(in_ready), 32'd0);
      tick();
      chk("st_hold_data", 32'(y_data), 32'h0042);
      chk("st_hold_valid", 32'(y_valid), 32'd1);
    end

    // Flush during LDWAIT discards the pending operand.
    idle(); in_valid = 1; src_ra = 5; exmem_we = 1; exmem_load = 1; exmem_rd = 5;
    tick();
    idle(); flush = 1; memwb_we = 1; memwb_rd = 5; memwb_data = 16'h7777;
    tick();
    idle();
    #1;
    chk("fl_valid", 32'(y_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    chk("fl_load_stall", 32'(load_stall), 32'd0);
    tick();

    // Asynchronous reset clears outputs without a clock edge.
    in_valid = 1; use_imm = 1; imm_data = 16'h1234;
    tick();
    chk("ar_pre_data", 32'(y_data), 32'h1234);
    idle();
    rst_n = 0;
    #1;
    chk("ar_valid", 32'(y_valid), 32'd0);
    chk("ar_data", 32'(y_data), 32'd0);
    chk("ar_src", 32'(y_src), 32'd0);
    @(negedge clk);
    tick();
    rst_n = 1;

    // Three EX forwards then one load bubble resolved via MEM/WB.
    for (int i = 0; i < 3; i++) begin
      idle(); in_valid = 1; src_ra = 3'(i + 1);
      exmem_we = 1; exmem_rd = 3'(i + 1); exmem_data = 16'(16'h0100 + i);
      tick();
    end
    idle(); in_valid = 1; src_ra = 4; exmem_we = 1; exmem_load = 1; exmem_rd = 4;
    tick();
    idle(); memwb_we = 1; memwb_rd = 4; memwb_data = 16'h4444;
    tick();
    idle();
    tick();
    chk("cnt_ex_lit", 32'(cnt_ex), CNT_ON ? 32'd3 : 32'd0);
    chk("cnt_ld_lit", 32'(cnt_ld), CNT_ON ? 32'd1 : 32'd0);
    chk("cnt_wb_lit", 32'(cnt_wb), CNT_ON ? 32'd1 : 32'd0);

    // Randomized traffic, biased toward register matches.
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 99) < 75);
      use_imm    = ($urandom_range(0, 99) < 20);
      imm_data   = 16'($urandom);
      rf_data    = 16'($urandom);
      src_ra     = 3'($urandom_range(0, 7));
      exmem_we   = ($urandom_range(0, 99) < 70);
      exmem_rd   = ($urandom_range(0, 99) < 45) ? src_ra : 3'($urandom_range(0, 7));
      exmem_data = 16'($urandom);
      exmem_load = ($urandom_range(0, 99) < 30);
      memwb_we   = ($urandom_range(0, 99) < 70);
      memwb_rd   = ($urandom_range(0, 99) < 45) ? src_ra : 3'($urandom_range(0, 7));
      memwb_data = 16'($urandom);
      stall      = ($urandom_range(0, 99) < 15);
      flush      = ($urandom_range(0, 99) < 5);
      tick();
    end
    idle();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
